mux_rr_reg: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer; successor to the team's gate-level 2:1 mux.
- Adds a valid/ready handshake on every input and on the output.
- Two selection modes: manual (external select) and round-robin (fair scan over valid channels).
- Sits between multiple producer streams and a single consumer; one registered output stage, one-cycle latency, full throughput.

---
 rtl/mux_rr_reg.sv | 108 ++++++++++
 tb/tb_mux_rr_reg.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_reg.sv
// N-channel registered mux: a manual select or a round-robin grant feeds one output register.
// Latency: 1 cycle from an input handshake to out_valid/out_data. Full throughput (1 word/cycle).
// Backpressure: while out_valid && !out_ready, all in_ready are 0 and the output and rr_ptr hold.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_data/in_valid     packed per-channel data (channel k at [k*DW +: DW]) and valids
//   in_ready             per-channel ready, combinational, at most one bit set
//   mode, sel            0 = manual (sel picks the channel), 1 = round-robin over valid channels
//   out_data/out_ch      registered word and the index of the channel that produced it
//   out_valid/out_ready  output handshake
module mux_rr_reg #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    localparam int SW  = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH*DW-1:0] in_data,
    input  logic [N_CH-1:0]    in_valid,
    output logic [N_CH-1:0]    in_ready,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    output logic [DW-1:0]      out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SW-1:0]      out_ch
);

    logic [SW-1:0]   rr_ptr;
    logic            load_en;
    logic [N_CH-1:0] grant;
    logic [N_CH-1:0] xfer_vec;
    logic            xfer;
    logic [SW-1:0]   xfer_ch;
    logic [DW-1:0]   xfer_dat;
    logic [SW-1:0]   nxt_ptr;

    // The register can take a word when it is empty or its word leaves this cycle.
    assign load_en = !out_valid || out_ready;

    // Grant is one-hot or empty. Manual mode ignores in_valid, so the selected channel
    // is readied even when idle. An out-of-range sel never matches any k, so nothing
    // is granted.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (!mode) begin
            for (int k = 0; k < N_CH; k++) begin
                if (int'(sel) == k) begin
                    grant[k] = 1'b1;
                end
            end
        end else begin
            // Scan upward from rr_ptr and wrap, so the last winner goes to the back of the queue.
            for (int i = 0; i < N_CH; i++) begin
                idx = (int'(rr_ptr) + i) % N_CH;
                if (!found && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    // Gated with rst_n so no producer sees a handshake while reset is asserted.
    assign in_ready = (rst_n && load_en) ? grant : '0;

    always_comb begin
        xfer_vec = in_valid & in_ready;
        xfer_ch  = '0;
        xfer_dat = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (xfer_vec[k]) begin
                xfer_ch  = SW'(k);
                xfer_dat = in_data[k*DW +: DW];
            end
        end
        xfer    = |xfer_vec;
        nxt_ptr = (xfer_ch == SW'(N_CH - 1)) ? '0 : xfer_ch + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                // Covers the simultaneous drain-and-load case: the new word replaces the old one.
                out_data  <= xfer_dat;
                out_ch    <= xfer_ch;
                out_valid <= 1'b1;
                // Manual transfers leave the pointer alone, so round-robin resumes where it stopped.
                if (mode) begin
                    rr_ptr <= nxt_ptr;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_reg.sv
module tb_mux_rr_reg;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] dat;
    } word_t;

    logic        clk;
    logic        rst_n;

    // Main DUT: 4 channels, 8 bits.
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    // Second DUT: 3 channels, so sel=3 is out of range.
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_ch3;

    int checks = 0;
    int errors = 0;

    // Scoreboard and reference state for the main DUT.
    word_t sb[$];
    int    m_ptr = 0;
    logic  m_ov  = 1'b0;

    mux_rr_reg #(.N_CH(4), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    mux_rr_reg #(.N_CH(3), .DW(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor on the main DUT. Inputs change just after posedge, so at negedge the
    // cycle's handshake is settled: predict the ready vector, pop the word leaving the register,
    // and push the word that will be loaded at the coming edge.
    logic [3:0] mon_g;
    logic [3:0] mon_r;
    logic       mon_found;
    logic       mon_nov;
    int         mon_k;
    word_t      mon_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mon_reset: in_ready=%b out_valid=%b, required 0000/0", in_ready, out_valid);
            end
            sb.delete();
            m_ptr = 0;
            m_ov  = 1'b0;
        end else begin
            mon_g = 4'b0000;
            if (!mode) begin
                mon_g[sel] = 1'b1;
            end else begin
                mon_found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    mon_k = (m_ptr + i) % 4;
                    if (!mon_found && in_valid[mon_k]) begin
                        mon_g[mon_k] = 1'b1;
                        mon_found    = 1'b1;
                    end
                end
            end
            mon_r = (!m_ov || out_ready) ? mon_g : 4'b0000;
            checks++;
            if (in_ready !== mon_r) begin
                errors++;
                $display("FAIL mon_in_ready: got %b, required %b", in_ready, mon_r);
            end
            checks++;
            if (out_valid !== m_ov) begin
                errors++;
                $display("FAIL mon_out_valid: got %b, required %b", out_valid, m_ov);
            end
            if (m_ov && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mon_underflow: word consumed with empty scoreboard");
                end else begin
                    mon_w = sb.pop_front();
                    if (out_data !== mon_w.dat || out_ch !== mon_w.ch) begin
                        errors++;
                        $display("FAIL mon_word: got ch=%0d data=%h, required ch=%0d data=%h",
                                 out_ch, out_data, mon_w.ch, mon_w.dat);
                    end
                end
            end
            mon_nov = m_ov && !out_ready;
            for (int k = 0; k < 4; k++) begin
                if (mon_r[k] && in_valid[k]) begin
                    sb.push_back({2'(k), in_data[k*8 +: 8]});
                    mon_nov = 1'b1;
                    if (mode) m_ptr = (k + 1) % 4;
                end
            end
            m_ov = mon_nov;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        repeat (3) tick();
        mid();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b out_data=%h out_ch=%0d in_ready=%b, required 0/00/0/0000",
                     out_valid, out_data, out_ch, in_ready);
        end
        tick();
        rst_n = 1'b1;
        mid();
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 0001", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
            errors++;
            $display("FAIL reset_first_word: valid=%b ch=%0d data=%h, required 1/0/10", out_valid, out_ch, out_data);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_manual();
        mode     = 1'b0;
        sel      = 2'd2;
        set_data(8'h01, 8'h02, 8'hA5, 8'h04);
        in_valid = 4'b1111;
        mid();
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL manual_ready: got %b, required 0100", in_ready);
        end
        tick();
        checks++;
        if (out_data !== 8'hA5 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL manual_word: data=%h ch=%0d valid=%b, required A5/2/1", out_data, out_ch, out_valid);
        end
        repeat (3) begin
            mid();
            checks++;
            if ((in_ready & 4'b1011) !== 4'b0000) begin
                errors++;
                $display("FAIL manual_others: in_ready=%b, channels 0,1,3 must stay 0", in_ready);
            end
            tick();
        end
        checks++;
        if (dut.rr_ptr !== 2'd1) begin
            errors++;
            $display("FAIL manual_ptr: rr_ptr=%0d, required 1", dut.rr_ptr);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_rr_fairness();
        rst_n = 1'b0;
        tick();
        mode     = 1'b1;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        in_valid = 4'b1111;
        rst_n    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) || out_data !== 8'(8'h10 + i % 4)) begin
                errors++;
                $display("FAIL rr_fair[%0d]: valid=%b ch=%0d data=%h, required 1/%0d/%h",
                         i, out_valid, out_ch, out_data, i % 4, 8'h10 + i % 4);
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_sparse_wrap();
        // rr_ptr is 0 here; a lone ch2 transfer moves it to 3.
        set_data(8'h40, 8'h55, 8'h22, 8'h43);
        in_valid = 4'b0100;
        tick();
        in_valid = 4'b0010;
        mid();
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL sparse_ready: got %b, required 0010", in_ready);
        end
        tick();
        checks++;
        if (out_ch !== 2'd1 || out_data !== 8'h55 || dut.rr_ptr !== 2'd2) begin
            errors++;
            $display("FAIL sparse_word: ch=%0d data=%h rr_ptr=%0d, required 1/55/2", out_ch, out_data, dut.rr_ptr);
        end
        in_valid = 4'b1001;
        mid();
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_ready: got %b, required 1000", in_ready);
        end
        tick();
        checks++;
        if (out_ch !== 2'd3 || out_data !== 8'h43) begin
            errors++;
            $display("FAIL wrap_first: ch=%0d data=%h, required 3/43", out_ch, out_data);
        end
        tick();
        checks++;
        if (out_ch !== 2'd0 || out_data !== 8'h40) begin
            errors++;
            $display("FAIL wrap_second: ch=%0d data=%h, required 0/40", out_ch, out_data);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        // rr_ptr is 1: ch1 loads 0x77 into the empty register even though out_ready is low.
        set_data(8'h10, 8'h77, 8'h12, 8'h13);
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        tick();
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            mid();
            checks++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h77 ||
                out_ch !== 2'd1 || dut.rr_ptr !== 2'd2) begin
                errors++;
                $display("FAIL backpressure[%0d]: in_ready=%b valid=%b data=%h ch=%0d rr_ptr=%0d, required 0000/1/77/1/2",
                         i, in_ready, out_valid, out_data, out_ch, dut.rr_ptr);
            end
            tick();
        end
        out_ready = 1'b1;
        mid();
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL release_ready: got %b, required 0100", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'h12) begin
            errors++;
            $display("FAIL release_word: valid=%b ch=%0d data=%h, required 1/2/12", out_valid, out_ch, out_data);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_mode_switch();
        // rr_ptr is 3; manual transfers on ch0 must not move it.
        mode     = 1'b0;
        sel      = 2'd0;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        in_valid = 4'b1111;
        tick();
        tick();
        checks++;
        if (out_ch !== 2'd0 || out_data !== 8'h10 || dut.rr_ptr !== 2'd3) begin
            errors++;
            $display("FAIL switch_manual: ch=%0d data=%h rr_ptr=%0d, required 0/10/3", out_ch, out_data, dut.rr_ptr);
        end
        mode = 1'b1;
        mid();
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL switch_resume: in_ready=%b, required 1000", in_ready);
        end
        tick();
        checks++;
        if (out_ch !== 2'd3 || out_data !== 8'h13) begin
            errors++;
            $display("FAIL switch_word: ch=%0d data=%h, required 3/13", out_ch, out_data);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_midstream();
        mode       = 1'b1;
        in_valid   = 4'b1111;
        out_ready  = 1'b0;
        mode3      = 1'b0;
        sel3       = 2'd2;
        in_data3   = {8'hC2, 8'hC1, 8'hC0};
        in_valid3  = 3'b111;
        out_ready3 = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_valid3 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: out_valid=%b out_valid3=%b, required 1/1", out_valid, out_valid3);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_valid3 !== 1'b0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_async: out_valid=%b out_data=%h out_valid3=%b in_ready=%b, required 0/00/0/0000",
                     out_valid, out_data, out_valid3, in_ready);
        end
        tick();
        tick();
        in_valid   = 4'b0000;
        in_valid3  = 3'b000;
        out_ready  = 1'b1;
        out_ready3 = 1'b1;
        rst_n      = 1'b1;
        tick();
    endtask

    task automatic test_out_of_range();
        mode3      = 1'b0;
        sel3       = 2'd3;
        in_data3   = {8'hC2, 8'hC1, 8'hC0};
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            checks++;
            if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
                errors++;
                $display("FAIL oor_sel[%0d]: in_ready3=%b out_valid3=%b, required 000/0", i, in_ready3, out_valid3);
            end
            tick();
        end
        sel3 = 2'd2;
        mid();
        checks++;
        if (in_ready3 !== 3'b100) begin
            errors++;
            $display("FAIL inrange_ready: in_ready3=%b, required 100", in_ready3);
        end
        tick();
        checks++;
        if (out_valid3 !== 1'b1 || out_ch3 !== 2'd2 || out_data3 !== 8'hC2) begin
            errors++;
            $display("FAIL inrange_word: valid=%b ch=%0d data=%h, required 1/2/C2", out_valid3, out_ch3, out_data3);
        end
        in_valid3 = 3'b000;
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = '0;
        mode       = 1'b1;
        sel        = '0;
        out_ready  = 1'b1;
        in_data3   = '0;
        in_valid3  = '0;
        mode3      = 1'b0;
        sel3       = '0;
        out_ready3 = 1'b1;

        test_reset();
        test_manual();
        test_rr_fairness();
        test_sparse_wrap();
        test_backpressure();
        test_mode_switch();
        test_reset_midstream();
        test_out_of_range();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
